// File: rtl/fifo_rd_arbiter.sv
// Round-robin read scheduler: one downstream consumer shared by N_SRC FIFO read ports,
// with burst grants, a one-cycle read pipeline and a 2-entry skid buffer.
module fifo_rd_arbiter #(
  parameter int N_SRC      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int SRC_W      = $clog2(N_SRC)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_SRC-1:0]            i_empty,
  input  logic [N_SRC*DATA_WIDTH-1:0] i_rd_data,
  output logic [N_SRC-1:0]            o_rd_en,
  output logic [DATA_WIDTH-1:0]       o_data,
  output logic [SRC_W-1:0]            o_src,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic                        o_busy
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  typedef enum logic {S_IDLE, S_BURST} state_e;

  typedef struct packed {
    logic [SRC_W-1:0]      src;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  state_e                           state_q, state_d;
  logic [SRC_W-1:0]                 grant_q, grant_d;
  logic [SRC_W-1:0]                 last_q, last_d;
  logic [BW-1:0]                    beat_q, beat_d;
  logic                             infl_q;
  logic [SRC_W-1:0]                 infl_src_q;
  logic [1:0]                       cnt_q, cnt_d;
  logic                             rd_ptr_q, wr_ptr_q;
  entry_t [1:0]                     buf_q;

  logic [N_SRC-1:0][DATA_WIDTH-1:0] rd_word;
  logic                             pick_vld;
  logic [SRC_W-1:0]                 pick_idx;
  logic [SRC_W:0]                   cand_sum;
  logic                             pop, space, issue;
  logic [2:0]                       occ;
  entry_t                           push_ent;

  for (genvar k = 0; k < N_SRC; k++) begin : g_unpack
    assign rd_word[k] = i_rd_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin scan starting just after the last served source; the smallest
  // offset wins because it is evaluated last.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand_sum = '0;
    for (int off = N_SRC; off >= 1; off--) begin
      cand_sum = {1'b0, last_q} + (SRC_W+1)'(off);
      if (cand_sum >= (SRC_W+1)'(N_SRC)) cand_sum = cand_sum - (SRC_W+1)'(N_SRC);
      if (!i_empty[cand_sum[SRC_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand_sum[SRC_W-1:0];
      end
    end
  end

  // A read may only issue if its word is guaranteed a buffer slot on arrival.
  assign pop   = o_valid & i_ready;
  assign occ   = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
  assign space = occ < 3'd2;
  assign issue = (state_q == S_BURST) & ~i_empty[grant_q] & space;

  always_comb begin
    o_rd_en = '0;
    if (issue) o_rd_en[grant_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beat_d  = beat_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d = S_BURST;
          grant_d = pick_idx;
          beat_d  = '0;
        end
      end
      S_BURST: begin
        if (issue) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = S_IDLE;
            last_d  = grant_q;
          end
        end else if (i_empty[grant_q]) begin
          state_d = S_IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({infl_q, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  assign push_ent.src  = infl_src_q;
  assign push_ent.data = rd_word[infl_src_q];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      last_q     <= SRC_W'(N_SRC - 1);
      beat_q     <= '0;
      infl_q     <= 1'b0;
      infl_src_q <= '0;
      cnt_q      <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      beat_q     <= beat_d;
      infl_q     <= issue;
      infl_src_q <= grant_q;
      cnt_q      <= cnt_d;
      if (infl_q) begin
        buf_q[wr_ptr_q] <= push_ent;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign o_valid = cnt_q != 2'd0;
  assign o_data  = buf_q[rd_ptr_q].data;
  assign o_src   = buf_q[rd_ptr_q].src;
  assign o_busy  = (state_q == S_BURST) | infl_q | (cnt_q != 2'd0);

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: queue-based FIFO environment plus a reference model of the
// scheduling rules, checked every cycle, with directed scenarios and a random phase.
module tb_fifo_rd_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            i_rst = 1'b1;
  logic [N-1:0]    i_empty = '1;
  logic [N*DW-1:0] i_rd_data = '0;
  logic            i_ready = 1'b0;
  logic [N-1:0]    o_rd_en;
  logic [DW-1:0]   o_data;
  logic [SW-1:0]   o_src;
  logic            o_valid;
  logic            o_busy;

  fifo_rd_arbiter #(.N_SRC(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_empty(i_empty), .i_rd_data(i_rd_data),
    .o_rd_en(o_rd_en), .o_data(o_data), .o_src(o_src), .o_valid(o_valid),
    .i_ready(i_ready), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct { int src; logic [DW-1:0] d; } wd_t;

  logic [DW-1:0] fq [N][$];
  wd_t           obuf[$];
  wd_t           pipe[$];
  bit            m_burst;
  int            m_g, m_last, m_beats;
  bit            m_issue, m_pop;
  bit [N-1:0]    ne;
  int            total, bad;
  bit            chk_on;
  int            bsrc[$], blen[$];
  int            encnt[N];
  bit            prev_en;
  int            prev_src;
  logic [SW+DW-1:0] acc[$];
  logic [DW-1:0] words[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(int k, logic [DW-1:0] d);
    fq[k].push_back(d);
    i_empty[k] = 1'b0;
  endtask

  task automatic clr_rec();
    bsrc.delete(); blen.delete(); acc.delete();
    for (int k = 0; k < N; k++) encnt[k] = 0;
    prev_en = 1'b0;
  endtask

  task automatic cycle();
    logic [N-1:0] exp_en;
    wd_t w;
    int s, k;
    #2;
    for (int j = 0; j < N; j++) ne[j] = fq[j].size() != 0;
    m_pop   = (obuf.size() != 0) && i_ready;
    m_issue = m_burst && ne[m_g] && ((obuf.size() + pipe.size() - int'(m_pop)) < 2);
    exp_en  = '0;
    if (m_issue) exp_en[m_g] = 1'b1;
    if (chk_on) begin
      chk("rd_en", 32'(o_rd_en), 32'(exp_en));
      chk("valid", 32'(o_valid), 32'(obuf.size() != 0));
      chk("busy", 32'(o_busy), 32'(m_burst || pipe.size() != 0 || obuf.size() != 0));
      if (obuf.size() != 0) begin
        chk("data", 32'(o_data), 32'(obuf[0].d));
        chk("src", 32'(o_src), 32'(obuf[0].src));
      end
    end
    // observation log for the directed scenarios
    s = 0;
    for (int j = 0; j < N; j++) if (o_rd_en[j]) s = j;
    if (o_rd_en != '0) begin
      encnt[s]++;
      if (!prev_en || s != prev_src) begin
        bsrc.push_back(s);
        blen.push_back(1);
      end else begin
        blen[blen.size()-1] = blen[blen.size()-1] + 1;
      end
    end
    prev_en  = o_rd_en != '0;
    prev_src = s;
    if (o_valid && i_ready) acc.push_back({o_src, o_data});

    @(posedge clk);
    #1;
    w.src = 0; w.d = '0;
    if (m_issue) begin
      w.src = m_g;
      w.d   = fq[m_g].pop_front();
    end
    if (i_rst) begin
      m_burst = 0; m_g = 0; m_last = N - 1; m_beats = 0;
      obuf.delete(); pipe.delete();
      for (int j = 0; j < N; j++) fq[j].delete();
    end else begin
      if (m_pop) void'(obuf.pop_front());
      if (pipe.size() != 0) obuf.push_back(pipe.pop_front());
      if (m_issue) pipe.push_back(w);
      if (!m_burst) begin
        for (int off = 1; off <= N; off++) begin
          k = (m_last + off) % N;
          if (ne[k]) begin
            m_g = k; m_burst = 1; m_beats = 0;
            break;
          end
        end
      end else if (m_issue) begin
        m_beats++;
        if (m_beats == MB) begin m_burst = 0; m_last = m_g; end
      end else if (!ne[m_g]) begin
        m_burst = 0; m_last = m_g;
      end
    end
    for (int j = 0; j < N; j++) i_rd_data[j*DW +: DW] = DW'($urandom);
    if (m_issue) i_rd_data[w.src*DW +: DW] = w.d;
    for (int j = 0; j < N; j++) i_empty[j] = fq[j].size() == 0;
  endtask

  task automatic do_reset(int n);
    i_rst = 1'b1;
    repeat (n) cycle();
    i_rst = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    m_burst = 0; m_g = 0; m_last = N - 1; m_beats = 0;
    clr_rec();

    // 1: reset and idle with every FIFO empty
    chk_on = 1'b0;
    cycle();
    chk_on = 1'b1;
    do_reset(2);
    #2;
    chk("rst_data", 32'(o_data), 32'h0);
    chk("rst_src", 32'(o_src), 32'h0);
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    repeat (20) cycle();

    // 2: single source with three words
    clr_rec();
    i_ready = 1'b1;
    push(2, 8'hA1); push(2, 8'hA2); push(2, 8'hA3);
    repeat (10) cycle();
    chk("t2_en_cnt", 32'(encnt[2]), 32'd3);
    chk("t2_bursts", 32'(bsrc.size()), 32'd1);
    chk("t2_len", 32'(blen.size() > 0 ? blen[0] : 0), 32'd3);
    chk("t2_acc_n", 32'(acc.size()), 32'd3);
    for (int i = 0; i < 3 && i < acc.size(); i++)
      chk("t2_word", 32'(acc[i]), 32'({2'd2, 8'hA1 + 8'(i)}));

    // 3: all sources loaded, fairness and burst length
    do_reset(1);
    clr_rec();
    for (int k = 0; k < N; k++) for (int i = 0; i < 10; i++) push(k, DW'($urandom));
    repeat (70) cycle();
    chk("t3_bursts_ge8", 32'(bsrc.size() >= 8), 32'd1);
    for (int i = 0; i < 8 && i < bsrc.size(); i++) begin
      chk("t3_src", 32'(bsrc[i]), 32'(i % N));
      chk("t3_len", 32'(blen[i]), 32'(MB));
    end
    chk("t3_acc_n", 32'(acc.size()), 32'd40);

    // 4: backpressure with a full FIFO 1
    do_reset(1);
    clr_rec();
    i_ready = 1'b0;
    words.delete();
    for (int i = 0; i < 8; i++) begin
      words.push_back(DW'($urandom));
      push(1, words[i]);
    end
    repeat (12) cycle();
    #2;
    chk("t4_en_cnt", 32'(encnt[1]), 32'd2);
    chk("t4_valid", 32'(o_valid), 32'd1);
    chk("t4_hold", 32'(o_data), 32'(words[0]));
    i_ready = 1'b1;
    repeat (25) cycle();
    chk("t4_acc_n", 32'(acc.size()), 32'd8);
    for (int i = 0; i < 8 && i < acc.size(); i++)
      chk("t4_word", 32'(acc[i]), 32'({2'd1, words[i]}));

    // 5: FIFO 3 becomes non-empty mid-burst with last=3
    do_reset(1);
    clr_rec();
    for (int i = 0; i < 6; i++) push(0, DW'($urandom));
    for (int i = 0; i < 3; i++) push(2, DW'($urandom));
    repeat (3) cycle();
    for (int i = 0; i < 3; i++) push(3, DW'($urandom));
    repeat (30) cycle();
    chk("t5_bursts", 32'(bsrc.size()), 32'd4);
    if (bsrc.size() == 4) begin
      chk("t5_b0", 32'(bsrc[0]), 32'd0);
      chk("t5_b1", 32'(bsrc[1]), 32'd2);
      chk("t5_b2", 32'(bsrc[2]), 32'd3);
      chk("t5_b3", 32'(bsrc[3]), 32'd0);
    end

    // 6: reset during a burst with a read in flight
    do_reset(1);
    push(2, 8'h11); push(2, 8'h22);
    repeat (8) cycle();
    for (int i = 0; i < 6; i++) push(3, DW'($urandom));
    repeat (3) cycle();
    do_reset(1);
    #2;
    chk("t6_valid", 32'(o_valid), 32'd0);
    chk("t6_rd_en", 32'(o_rd_en), 32'd0);
    chk("t6_busy", 32'(o_busy), 32'd0);
    clr_rec();
    push(3, 8'h33); push(0, 8'h44);
    repeat (10) cycle();
    chk("t6_first", 32'(bsrc.size() > 0 ? bsrc[0] : 99), 32'd0);

    // random traffic, backpressure and occasional resets
    for (int c = 0; c < 2000; c++) begin
      int k;
      i_ready = $urandom_range(9) < 7;
      if ($urandom_range(1) == 1) begin
        k = $urandom_range(N - 1);
        if (fq[k].size() < 16) push(k, DW'($urandom));
      end
      i_rst = $urandom_range(299) == 0;
      cycle();
    end
    i_rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
